// File: rtl/el2_trace_buf.sv
// el2_trace_buf: retirement-trace capture FIFO that drops on overflow and tags the next stored entry.
// Optional 16-bit saturating drop counter is built only when RV_TRACE_DROPCNT_EN is defined.
package el2_pkg;
    typedef struct packed {
        logic [31:0] rv_i_insn_ip;
        logic [31:0] rv_i_address_ip;
        logic [1:0]  rv_i_valid_ip;
        logic [1:0]  rv_i_exception_ip;
        logic [4:0]  rv_i_ecause_ip;
        logic [1:0]  rv_i_interrupt_ip;
        logic [31:0] rv_i_tval_ip;
    } el2_trace_pkt_t;
endpackage

module el2_trace_buf #(
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_l,
    input  el2_pkg::el2_trace_pkt_t   trace_pkt_i,
    input  logic                      trace_en,
    input  logic                      ovf_clr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [106:0]              out_pkt,
    output logic                      out_ovf,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [107:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         drop_pending;
    logic         live;
    logic         push_req;
    logic         pop;
    logic         full;
    logic         push_ok;
    logic         drop;

    assign live      = |trace_pkt_i.rv_i_valid_ip | |trace_pkt_i.rv_i_exception_ip
                     | |trace_pkt_i.rv_i_interrupt_ip;
    assign push_req  = trace_en & live;
    assign level     = wr_ptr - rd_ptr;
    assign full      = (level == FULL_LVL);
    assign out_valid = (level != '0);
    assign pop       = out_valid & out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok   = push_req & (~full | pop);
    assign drop      = push_req & full & ~pop;
    assign {out_ovf, out_pkt} = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[AW-1:0]] <= {drop_pending, trace_pkt_i};
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // ovf_clr only touches the software-visible status, never drop_pending.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            drop_pending <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (drop) begin
                drop_pending <= 1'b1;
            end else if (push_ok) begin
                drop_pending <= 1'b0;
            end
            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef RV_TRACE_DROPCNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            drop_cnt_q <= '0;
        end else if (drop) begin
            if (ovf_clr) begin
                drop_cnt_q <= 16'd1;
            end else if (drop_cnt_q != 16'hFFFF) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end else if (ovf_clr) begin
            drop_cnt_q <= '0;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = 16'h0;
`endif

endmodule
